// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing a single-port data RAM between two requesters,
// with a sequential clear engine that zero-writes the low CLR_DEPTH words,
// one word per cycle.
module ram_arbiter #(
  parameter int DW        = 32,
  parameter int AW        = 8,
  parameter int CLR_DEPTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_adr,
  input  logic [DW-1:0] r0_din,
  output logic          r0_gnt,
  output logic [DW-1:0] r0_rdata,
  output logic          r0_valid,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_adr,
  input  logic [DW-1:0] r1_din,
  output logic          r1_gnt,
  output logic [DW-1:0] r1_rdata,
  output logic          r1_valid,
  output logic          ram_we,
  output logic [AW-1:0] ram_adr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, GNT, CLEAR} state_t;

  localparam logic [AW-1:0] CLR_LAST = AW'(CLR_DEPTH - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          gsel_q, gsel_d;
  logic          clr_pend_q, clr_pend_d;
  logic [DW-1:0] r0_rdata_q, r0_rdata_d;
  logic [DW-1:0] r1_rdata_q, r1_rdata_d;
  logic          r0_valid_q, r0_valid_d;
  logic          r1_valid_q, r1_valid_d;
  logic          r0_gnt_q, r0_gnt_d;
  logic          r1_gnt_q, r1_gnt_d;
  logic          busy_q, busy_d;
  logic          sel_we;

  assign sel_we = gsel_q ? r1_we : r0_we;

  // Next-state: clear has priority over requests; ties go to the requester not served last.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    gsel_d     = gsel_q;
    clr_pend_d = clr_pend_q;
    r0_rdata_d = r0_rdata_q;
    r1_rdata_d = r1_rdata_q;
    r0_valid_d = 1'b0;
    r1_valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start || clr_pend_q) begin
          state_d    = CLEAR;
          clr_pend_d = 1'b0;
        end else if (r0_req || r1_req) begin
          gsel_d  = (r0_req && r1_req) ? ~last_q : r1_req;
          last_d  = gsel_d;
          state_d = GNT;
        end
      end
      GNT: begin
        state_d = IDLE;
        if (start) clr_pend_d = 1'b1;
        if (!sel_we) begin
          if (gsel_q) begin
            r1_rdata_d = ram_dout;
            r1_valid_d = 1'b1;
          end else begin
            r0_rdata_d = ram_dout;
            r0_valid_d = 1'b1;
          end
        end
      end
      CLEAR: begin
        if (cnt_q == CLR_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    r0_gnt_d = (state_d == GNT) && !gsel_d;
    r1_gnt_d = (state_d == GNT) && gsel_d;
    busy_d   = (state_d == CLEAR);
  end

  // State and registered outputs; reset aborts any clear or grant in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_q     <= 1'b1;
      gsel_q     <= 1'b0;
      clr_pend_q <= 1'b0;
      r0_rdata_q <= '0;
      r1_rdata_q <= '0;
      r0_valid_q <= 1'b0;
      r1_valid_q <= 1'b0;
      r0_gnt_q   <= 1'b0;
      r1_gnt_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      gsel_q     <= gsel_d;
      clr_pend_q <= clr_pend_d;
      r0_rdata_q <= r0_rdata_d;
      r1_rdata_q <= r1_rdata_d;
      r0_valid_q <= r0_valid_d;
      r1_valid_q <= r1_valid_d;
      r0_gnt_q   <= r0_gnt_d;
      r1_gnt_q   <= r1_gnt_d;
      busy_q     <= busy_d;
    end
  end

  // RAM port mux: granted requester passes straight through, clear drives zeros at cnt.
  always_comb begin
    ram_we  = 1'b0;
    ram_adr = '0;
    ram_din = '0;
    unique case (state_q)
      GNT: begin
        ram_we  = sel_we;
        ram_adr = gsel_q ? r1_adr : r0_adr;
        ram_din = gsel_q ? r1_din : r0_din;
      end
      CLEAR: begin
        ram_we  = 1'b1;
        ram_adr = cnt_q;
        ram_din = '0;
      end
      default: ;
    endcase
  end

  assign r0_gnt   = r0_gnt_q;
  assign r1_gnt   = r1_gnt_q;
  assign r0_rdata = r0_rdata_q;
  assign r1_rdata = r1_rdata_q;
  assign r0_valid = r0_valid_q;
  assign r1_valid = r1_valid_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: RAM model, cycle reference model with shadow memory,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ram_arbiter;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int CD = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start;
  logic          req_b [2];
  logic          we_b  [2];
  logic [AW-1:0] adr_b [2];
  logic [DW-1:0] din_b [2];
  logic          r0_gnt, r1_gnt, r0_valid, r1_valid, ram_we, busy;
  logic [DW-1:0] r0_rdata, r1_rdata, ram_din, ram_dout;
  logic [AW-1:0] ram_adr;

  logic [DW-1:0] mem [256] = '{default: 32'hC0DE_0000};

  ram_arbiter #(.DW(DW), .AW(AW), .CLR_DEPTH(CD)) dut (
    .clk(clk), .rst(rst), .start(start),
    .r0_req(req_b[0]), .r0_we(we_b[0]), .r0_adr(adr_b[0]), .r0_din(din_b[0]),
    .r0_gnt(r0_gnt), .r0_rdata(r0_rdata), .r0_valid(r0_valid),
    .r1_req(req_b[1]), .r1_we(we_b[1]), .r1_adr(adr_b[1]), .r1_din(din_b[1]),
    .r1_gnt(r1_gnt), .r1_rdata(r1_rdata), .r1_valid(r1_valid),
    .ram_we(ram_we), .ram_adr(ram_adr), .ram_din(ram_din), .ram_dout(ram_dout),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Single-port RAM: combinational read, write at the rising edge.
  assign ram_dout = mem[ram_adr];
  always @(posedge clk) if (ram_we) mem[ram_adr] <= ram_din;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: remaining clear cycles, current grant, pending clear, last winner.
  int            m_clr_left = 0;
  int            m_grant = -1;
  int            m_last = 1;
  bit            m_pend = 0;
  logic [DW-1:0] m_rdata [2] = '{default: '0};
  bit            m_valid [2] = '{default: 0};
  logic [DW-1:0] shadow [256] = '{default: 32'hC0DE_0000};

  bit            prev_busy = 0;
  int            busy_first = 0, busy_last = 0, busy_run = 0;
  int            gq_cyc [$];
  int            gq_who [$];
  logic          gq_we  [$];
  logic [AW-1:0] gq_adr [$];
  logic [DW-1:0] gq_din [$];

  always @(negedge clk) begin : cmp
    int g;
    logic ew;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    if (rst) begin
      m_clr_left = 0; m_grant = -1; m_last = 1; m_pend = 0;
      m_rdata[0] = '0; m_rdata[1] = '0; m_valid[0] = 0; m_valid[1] = 0;
    end
    ew = 1'b0; ea = '0; ed = '0;
    if (m_clr_left > 0) begin
      ew = 1'b1; ea = AW'(CD - m_clr_left);
    end else if (m_grant >= 0) begin
      ew = we_b[m_grant]; ea = adr_b[m_grant]; ed = din_b[m_grant];
    end
    chk("ctl{busy,g1,g0,v1,v0,we}", 64'({busy, r1_gnt, r0_gnt, r1_valid, r0_valid, ram_we}),
        64'({m_clr_left > 0, m_grant == 1, m_grant == 0, m_valid[1], m_valid[0], ew}));
    chk("ram_adr", 64'(ram_adr), 64'(ea));
    chk("ram_din", 64'(ram_din), 64'(ed));
    chk("r0_rdata", 64'(r0_rdata), 64'(m_rdata[0]));
    chk("r1_rdata", 64'(r1_rdata), 64'(m_rdata[1]));
    if (busy) begin
      if (!prev_busy) begin busy_first = cyc; busy_run = 0; end
      busy_run++;
      busy_last = cyc;
    end
    prev_busy = busy;
    if (r0_gnt || r1_gnt) begin
      gq_cyc.push_back(cyc); gq_who.push_back(r1_gnt ? 1 : 0);
      gq_we.push_back(ram_we); gq_adr.push_back(ram_adr); gq_din.push_back(ram_din);
    end
    if (!rst) begin
      m_valid[0] = 0; m_valid[1] = 0;
      if (m_clr_left > 0) begin
        shadow[CD - m_clr_left] = '0;
        m_clr_left--;
      end else if (m_grant >= 0) begin
        g = m_grant;
        if (we_b[g]) shadow[adr_b[g]] = din_b[g];
        else begin m_rdata[g] = shadow[adr_b[g]]; m_valid[g] = 1; end
        if (start) m_pend = 1;
        m_grant = -1;
      end else if (start || m_pend) begin
        m_clr_left = CD; m_pend = 0;
      end else if (req_b[0] || req_b[1]) begin
        g = (req_b[0] && req_b[1]) ? 1 - m_last : (req_b[0] ? 0 : 1);
        m_last = g; m_grant = g;
      end
    end
  end

  // One access: raise req, hold until gnt, drop it in the following cycle.
  task automatic access(input int i, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output int gcyc);
    bit got = 0;
    req_b[i] = 1'b1; we_b[i] = w; adr_b[i] = a; din_b[i] = d;
    gcyc = -1;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if ((i == 0) ? r0_gnt : r1_gnt) begin got = 1; gcyc = cyc; end
    end
    if (!got) chk("gnt_timeout", 64'(got), 64'(1));
    @(posedge clk); #1;
    req_b[i] = 1'b0;
  endtask

  task automatic wait_clear(input string nm);
    bit seen = 0, done = 0;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (busy) seen = 1;
      else if (seen) done = 1;
    end
    chk(nm, 64'(done), 64'(1));
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic rand_traffic(input int i);
    int gc;
    for (int k = 0; k < 25; k++) begin
      access(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 47)), $urandom, gc);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
  endtask

  initial begin : watchdog
    #1000000;
    n_err++;
    $display("FAIL watchdog: simulation did not complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int rc, gc;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_b[i] = 1'b0; we_b[i] = 1'b0; adr_b[i] = '0; din_b[i] = '0;
    end
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_gnt", 64'({r1_gnt, r0_gnt}), 64'(0));
    chk("rst_ram", 64'({ram_we, ram_adr}), 64'(0));
    chk("rst_rdata0", 64'(r0_rdata), 64'(0));

    // Single write then read by r0.
    gq_cyc.delete(); gq_who.delete(); gq_we.delete(); gq_adr.delete(); gq_din.delete();
    rc = cyc;
    access(0, 1'b1, 8'h05, 32'hDEADBEEF, gc);
    chk("wr_latency", 64'(gc - rc), 64'(1));
    chk("wr_we_after", 64'(ram_we), 64'(0));
    rc = cyc;
    access(0, 1'b0, 8'h05, 32'h0, gc);
    chk("rd_latency", 64'(gc - rc), 64'(1));
    chk("rd_valid", 64'(r0_valid), 64'(1));
    chk("rd_data", 64'(r0_rdata), 64'(32'hDEADBEEF));
    chk("t1_ngnt", 64'(gq_cyc.size()), 64'(2));
    if (gq_cyc.size() >= 2) begin
      chk("t1_wr_port", 64'({gq_we[0], gq_adr[0], gq_din[0]}), 64'({1'b1, 8'h05, 32'hDEADBEEF}));
      chk("t1_rd_we", 64'(gq_we[1]), 64'(0));
    end
    @(posedge clk); #1;
    chk("rd_valid_pulse", 64'(r0_valid), 64'(0));

    // Tie: both held for 4 accesses, fresh reset so r0 wins the first tie.
    rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
    gq_cyc.delete(); gq_who.delete(); gq_we.delete(); gq_adr.delete(); gq_din.delete();
    fork
      begin int g0; for (int k = 0; k < 4; k++) access(0, 1'b1, AW'(100 + k), $urandom, g0); end
      begin int g1; for (int k = 0; k < 4; k++) access(1, 1'b0, AW'(110 + k), '0, g1); end
    join
    chk("tie_ngnt", 64'(gq_cyc.size()), 64'(8));
    for (int k = 0; k < gq_cyc.size(); k++) begin
      chk("tie_order", 64'(gq_who[k]), 64'(k % 2));
      if (k > 0) chk("tie_spacing", 64'(gq_cyc[k] - gq_cyc[k-1]), 64'(2));
    end

    // Preload 0..40 with ones, clear, verify extent.
    for (int a = 0; a <= 40; a++) access(0, 1'b1, AW'(a), 32'hFFFFFFFF, gc);
    rc = cyc;
    pulse_start();
    wait_clear("clr_done");
    chk("clr_len", 64'(busy_run), 64'(32));
    chk("clr_first", 64'(busy_first), 64'(rc + 1));
    for (int a = 0; a <= 40; a++)
      chk("clr_mem", 64'(mem[a]), 64'((a < 32) ? 32'h0 : 32'hFFFFFFFF));
    access(1, 1'b0, 8'd31, '0, gc);
    chk("clr_rd31", 64'(r1_rdata), 64'(32'h0));
    access(1, 1'b0, 8'd32, '0, gc);
    chk("clr_rd32", 64'(r1_rdata), 64'(32'hFFFFFFFF));

    // r1 waiting through a clear.
    pulse_start();
    repeat (3) @(posedge clk);
    #1;
    access(1, 1'b0, 8'd7, '0, gc);
    chk("r1_after_clear", 64'(gc), 64'(busy_last + 2));

    // start coincident with an r0 grant, then re-pulsed mid-clear.
    fork
      access(0, 1'b1, 8'd200, 32'h00001234, gc);
      begin @(posedge clk); #1 start = 1'b1; @(posedge clk); #1 start = 1'b0; end
    join
    repeat (10) @(posedge clk);
    #1;
    pulse_start();
    wait_clear("pend_done");
    chk("pend_first", 64'(busy_first), 64'(gc + 2));
    chk("pend_len", 64'(busy_run), 64'(32));
    chk("pend_wr", 64'(mem[200]), 64'(32'h00001234));

    // Reset at clear cycle 10.
    for (int a = 0; a < 32; a++) access(0, 1'b1, AW'(a), 32'hFFFFFFFF, gc);
    pulse_start();
    repeat (10) @(posedge clk);
    #1;
    chk("pre_rst", 64'({busy, ram_we, ram_adr}), 64'({1'b1, 1'b1, 8'd10}));
    rst = 1'b1;
    #1;
    chk("arst_ctl", 64'({busy, r1_gnt, r0_gnt, r1_valid, r0_valid, ram_we}), 64'(0));
    chk("arst_ram", 64'({ram_adr, ram_din}), 64'(0));
    chk("arst_rdata", 64'({r1_rdata, r0_rdata}), 64'(0));
    @(posedge clk); #1 rst = 1'b0;
    for (int a = 0; a < 32; a++)
      chk("abort_mem", 64'(mem[a]), 64'((a < 10) ? 32'h0 : 32'hFFFFFFFF));

    // Randomized traffic with occasional clears.
    fork
      rand_traffic(0);
      rand_traffic(1);
      begin
        for (int k = 0; k < 3; k++) begin
          repeat ($urandom_range(20, 60)) @(posedge clk);
          #1;
          pulse_start();
        end
      end
    join
    repeat (4) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Sequences and shares the single-port 256x32 data RAM between two requesters (r0, r1) using round-robin arbitration.
- Replaces the RAM's parallel clear with a sequential clear engine: one zero-write per cycle over the low CLR_DEPTH words.
- Sits between the requesters and the RAM. It is the only driver of the RAM's we/adr/din and samples the RAM's combinational dout.

Parameters:
- DW, 32, data width.
- AW, 8, address width.
- CLR_DEPTH, 32, number of words zeroed by a clear, starting at address 0 (1..2^AW).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  clear request pulse.
- r0_req  input  1  requester 0 access request; held until r0_gnt.
- r0_we  input  1  requester 0 write (1) / read (0); stable while r0_req.
- r0_adr  input  AW  requester 0 address; stable while r0_req.
- r0_din  input  DW  requester 0 write data; stable while r0_req.
- r0_gnt  output  1  one-cycle grant; the access executes in this cycle.
- r0_rdata  output  DW  read data, registered.
- r0_valid  output  1  one-cycle pulse: r0_rdata updated (reads only).
- r1_*  same set as r0_*, for requester 1.
- ram_we  output  1  RAM write enable.
- ram_adr  output  AW  RAM address.
- ram_din  output  DW  RAM write data.
- ram_dout  input  DW  RAM combinational read data.
- busy  output  1  high while the clear engine runs.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, cnt=0, last=1 (so r0 wins the first tie), clr_pend=0.
  - All gnt, valid and busy outputs = 0; r0_rdata = r1_rdata = 0.
  - ram_we=0, ram_adr=0, ram_din=0.
- States are IDLE, GNT and CLEAR. Grant select gsel is registered.
- IDLE:
  - ram_we=0, ram_adr=0, ram_din=0.
  - If start=1 or clr_pend=1: go to CLEAR, clear clr_pend. Clear has priority over requests.
  - Otherwise, if any req: go to GNT. gsel = the only requester if one; on a tie, the requester other than last. Set last=gsel.
- GNT (exactly 1 cycle):
  - rG_gnt=1 for the granted requester.
  - ram_we/ram_adr/ram_din are driven combinationally from the granted requester's inputs.
  - Write: the RAM writes at the closing edge.
  - Read: rG_rdata <= ram_dout at the closing edge; rG_valid=1 in the next cycle.
  - Always return to IDLE.
- Latency and throughput:
  - req high in cycle n (state IDLE) -> gnt in cycle n+1 -> valid/rdata in cycle n+2.
  - Maximum throughput is one access per 2 cycles.
- Requester protocol:
  - Keep req high until gnt is seen.
  - A req still high in the cycle after gnt is a new request.
  - Changing we/adr/din while req is high and before gnt is illegal.
- CLEAR:
  - busy=1, ram_we=1, ram_din=0, ram_adr=cnt; cnt increments every cycle.
  - On the cycle where cnt==CLR_DEPTH-1: cnt<=0, go to IDLE.
  - A clear takes exactly CLR_DEPTH cycles. No gnt is issued during CLEAR; requests wait.
  - start during CLEAR is ignored (no restart, no pend).
- start during GNT: set clr_pend. CLEAR is entered after the following IDLE cycle.
- Reads hitting an address being cleared are impossible (CLEAR and GNT are mutually exclusive).
- The cnt width covers CLR_DEPTH. ram_adr = cnt[AW-1:0].
- Reset mid-CLEAR aborts immediately: cnt=0, IDLE, busy=0. Already-zeroed words stay zero; the rest are untouched.
- Reset mid-GNT: the write is not guaranteed; valid is not issued.
- Unused rdata holds its value until the next read by that requester.

Test Plan:
- Reset, then r0 write adr=0x05 din=0xDEADBEEF; r0 read adr=0x05.
  - gnt one cycle after req; ram_we=1 only in the write gnt cycle.
  - r0_valid 2 cycles after the read req, r0_rdata=0xDEADBEEF.
- r0_req and r1_req raised together and held for 4 accesses each.
  - Grants go r0, r1, r0, r1..., one grant every 2 cycles, never both in the same cycle.
- Preload words 0..40 with 0xFFFFFFFF, pulse start.
  - busy high exactly 32 cycles; ram_adr steps 0..31 with ram_din=0.
  - Readback: words 0..31 = 0; words 32..40 = 0xFFFFFFFF.
- r1_req held high during a clear.
  - No r1_gnt while busy; r1_gnt in the cycle after CLEAR->IDLE plus one.
- start pulse coincident with an r0 GNT cycle.
  - r0 access completes; CLEAR begins 2 cycles later.
  - start re-pulsed mid-clear does not extend busy beyond 32 cycles.
- Assert rst at clear cycle 10.
  - busy=0 and all outputs at reset values asynchronously.
  - Words 0..9 = 0; words 10..31 keep their prior 0xFFFFFFFF.
